piso_serializer: RTL

Parallel-in serial-out shift register with a load handshake and bit framing. Accepts a WIDTH-bit word, shifts it out MSB-first one bit per clock, and flags each valid bit and the frame's last bit. It is the transmit end for the team's serial-in parallel-out register: feeding o_sd into its serial input for WIDTH clocks reconstructs the original word.

---
 rtl/piso_serializer.sv | 109 ++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: MSB-first parallel-in serial-out shifter with load handshake and bit framing.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_load,
  output logic             o_ready,
  output logic             o_sd,
  output logic             o_sv,
  output logic             o_last
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] PreLastCnt = CntW'(WIDTH - 2);

`ifdef PISO_PARITY_EN
  localparam logic LastOnData = 1'b0;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_t;
`else
  localparam logic LastOnData = 1'b1;
  typedef enum logic [0:0] {StIdle, StShift} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CntW-1:0]  r_cnt;
  logic             r_ready;
  logic             r_sd;
  logic             r_sv;
  logic             r_last;
`ifdef PISO_PARITY_EN
  logic             r_par;
`endif

  // r_ready is high exactly in IDLE and on the final bit of a frame, so it doubles as the
  // "frame may end here" flag.
  logic w_accept;
  assign w_accept = i_load & r_ready;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= StIdle;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_sd    <= 1'b0;
      r_sv    <= 1'b0;
      r_last  <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state <= StShift;
      r_sr    <= i_data;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_sd    <= i_data[WIDTH-1];
      r_sv    <= 1'b1;
      r_last  <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (r_ready) begin
      r_state <= StIdle;
      r_ready <= 1'b1;
      r_sd    <= 1'b0;
      r_sv    <= 1'b0;
      r_last  <= 1'b0;
    end else if (r_state == StShift) begin
      r_sr  <= r_sr << 1;
      r_cnt <= r_cnt + 1'b1;
      r_sv  <= 1'b1;
      r_sd  <= r_sr[WIDTH-2];
`ifdef PISO_PARITY_EN
      r_par <= r_par ^ r_sr[WIDTH-1];
      if (r_cnt == LastCnt) begin
        // Last data bit just went out: emit the accumulated parity.
        r_state <= StPar;
        r_sd    <= r_par ^ r_sr[WIDTH-1];
        r_last  <= 1'b1;
        r_ready <= 1'b1;
      end else
`endif
      if (r_cnt == PreLastCnt) begin
        r_last  <= LastOnData;
        r_ready <= LastOnData;
      end else begin
        r_last  <= 1'b0;
        r_ready <= 1'b0;
      end
    end else begin
      r_state <= StIdle;
      r_ready <= 1'b1;
      r_sd    <= 1'b0;
      r_sv    <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_ready = r_ready;
  assign o_sd    = r_sd;
  assign o_sv    = r_sv;
  assign o_last  = r_last;

endmodule
